tag_mem_model: RTL and testbench

- Parametrised backing-memory model for the tag-cache simulation top. It serves the cache's memory command, write-data and read-response channels.
- Successor to the fixed, zero-latency memory stub. Adds configurable line size, depth, ID width, read latency and outstanding-read depth.
- Adds backpressure on every channel and saturating traffic counters for the random tester to check.

---
 rtl/tag_mem_model.sv | 165 ++++++++++++++++
 tb/tb_tag_mem_model.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tag_mem_model.sv
// tag_mem_model: parametrised backing-memory model for the tag-cache simulation top.
// Stores BEATS words per line, accepts line writes as a command followed by
// BEATS data beats, and returns reads in acceptance order after LATENCY cycles.
// Up to MAX_OUT reads may be outstanding.
//
// Ports:
//   clk, reset_n                   clock, asynchronous active-low reset
//   cmd_valid/ready/addr/rw/tag    command channel (rw: 1 = write, 0 = read)
//   data_valid/ready/bits          write-data beats for the accepted write
//   resp_valid/ready/data/tag      read-response beats, in acceptance order
//   rd_count, wr_count             saturating counts of accepted reads and completed writes
module tag_mem_model #(
  parameter int ADDR_W     = 26,
  parameter int DATA_W     = 128,
  parameter int BEATS      = 4,
  parameter int TAG_W      = 5,
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 8,
  parameter int MAX_OUT    = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic              cmd_rw,
  input  logic [TAG_W-1:0]  cmd_tag,
  input  logic              data_valid,
  output logic              data_ready,
  input  logic [DATA_W-1:0] data_bits,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic [TAG_W-1:0]  resp_tag,
  output logic [31:0]       rd_count,
  output logic [31:0]       wr_count
);

  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int CNT_W  = $clog2(LATENCY + 1);
  localparam int PTR_W  = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int OCC_W  = $clog2(MAX_OUT + 1);
  localparam int WORD_W = DEPTH_LOG2 + BEAT_W;
  localparam int WORDS  = (1 << DEPTH_LOG2) * BEATS;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_WDATA = 1'b1;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  function automatic logic [WORD_W-1:0] word_addr(input logic [DEPTH_LOG2-1:0] line,
                                                   input logic [BEAT_W-1:0] beat);
    return WORD_W'(line) * WORD_W'(BEATS) + WORD_W'(beat);
  endfunction

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUT - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  logic [DATA_W-1:0]     mem [WORDS];

  logic                  live;
  logic [0:0]            state;
  logic [DEPTH_LOG2-1:0] wline;
  logic [BEAT_W-1:0]     wbeat;
  logic [BEAT_W-1:0]     rbeat;

  logic [DEPTH_LOG2-1:0] q_line [MAX_OUT];
  logic [TAG_W-1:0]      q_tag  [MAX_OUT];
  logic [CNT_W-1:0]      q_cnt  [MAX_OUT];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [OCC_W-1:0]      occ;

  logic full, cmd_fire, rd_push, wr_start, beat_fire, resp_fire, pop;

  generate
    if (ADDR_W > DEPTH_LOG2) begin : g_addr_hi
      logic unused_addr_hi;
      assign unused_addr_hi = ^cmd_addr[ADDR_W-1:DEPTH_LOG2];
    end
  endgenerate

  // Full flag comes only from registered occupancy, so a same-cycle pop never
  // frees a slot for a read command.
  assign full       = (occ == OCC_W'(MAX_OUT));
  assign cmd_ready  = live && (state == S_IDLE) && (cmd_rw || !full);
  assign cmd_fire   = cmd_valid && cmd_ready;
  assign rd_push    = cmd_fire && !cmd_rw;
  assign wr_start   = cmd_fire && cmd_rw;
  assign data_ready = (state == S_WDATA);
  assign beat_fire  = data_valid && data_ready;

  // Data is read from the array at emission time, so a completed write to the
  // same line before a beat goes out is reflected in that beat.
  assign resp_valid = (occ != '0) && (q_cnt[rd_ptr] == '0);
  assign resp_tag   = resp_valid ? q_tag[rd_ptr] : '0;
  assign resp_data  = resp_valid ? mem[word_addr(q_line[rd_ptr], rbeat)] : '0;
  assign resp_fire  = resp_valid && resp_ready;
  assign pop        = resp_fire && (rbeat == BEAT_W'(BEATS - 1));

  // Control state: write FSM, read queue bookkeeping and statistics
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      live     <= 1'b0;
      state    <= S_IDLE;
      wbeat    <= '0;
      rbeat    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
      rd_count <= '0;
      wr_count <= '0;
      for (int i = 0; i < MAX_OUT; i++) q_cnt[i] <= '0;
    end else begin
      live <= 1'b1;

      if (wr_start) begin
        state <= S_WDATA;
        wbeat <= '0;
      end else if (beat_fire) begin
        if (wbeat == BEAT_W'(BEATS - 1)) begin
          state    <= S_IDLE;
          wbeat    <= '0;
          wr_count <= sat_inc(wr_count);
        end else begin
          wbeat <= wbeat + BEAT_W'(1);
        end
      end

      // Countdowns run regardless of response backpressure; a new entry
      // starts at LATENCY and is not decremented on its push edge.
      for (int i = 0; i < MAX_OUT; i++) begin
        if (rd_push && (wr_ptr == PTR_W'(i))) q_cnt[i] <= CNT_W'(LATENCY);
        else if (q_cnt[i] != '0)               q_cnt[i] <= q_cnt[i] - CNT_W'(1);
      end

      if (rd_push) begin
        wr_ptr   <= ptr_next(wr_ptr);
        rd_count <= sat_inc(rd_count);
      end

      if (resp_fire) rbeat <= pop ? '0 : rbeat + BEAT_W'(1);
      if (pop)       rd_ptr <= ptr_next(rd_ptr);

      case ({rd_push, pop})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Data path: array, queue payload and write line latch are never reset
  always_ff @(posedge clk) begin
    if (rd_push) begin
      q_line[wr_ptr] <= cmd_addr[DEPTH_LOG2-1:0];
      q_tag[wr_ptr]  <= cmd_tag;
    end
    if (wr_start)  wline <= cmd_addr[DEPTH_LOG2-1:0];
    if (beat_fire) mem[word_addr(wline, wbeat)] <= data_bits;
  end

endmodule

// File: tb/tb_tag_mem_model.sv
module tb_tag_mem_model;
  localparam int ADDR_W     = 26;
  localparam int DATA_W     = 128;
  localparam int BEATS      = 4;
  localparam int TAG_W      = 5;
  localparam int DEPTH_LOG2 = 10;
  localparam int LATENCY    = 8;
  localparam int MAX_OUT    = 4;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              cmd_valid, cmd_ready, cmd_rw;
  logic [ADDR_W-1:0] cmd_addr;
  logic [TAG_W-1:0]  cmd_tag;
  logic              data_valid, data_ready;
  logic [DATA_W-1:0] data_bits;
  logic              resp_valid, resp_ready;
  logic [DATA_W-1:0] resp_data;
  logic [TAG_W-1:0]  resp_tag;
  logic [31:0]       rd_count, wr_count;

  always #5 clk = ~clk;

  tag_mem_model #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BEATS(BEATS), .TAG_W(TAG_W),
    .DEPTH_LOG2(DEPTH_LOG2), .LATENCY(LATENCY), .MAX_OUT(MAX_OUT)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_rw(cmd_rw), .cmd_tag(cmd_tag),
    .data_valid(data_valid), .data_ready(data_ready), .data_bits(data_bits),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_tag(resp_tag), .rd_count(rd_count), .wr_count(wr_count)
  );

  // Reference model: memory as a sparse word map, outstanding reads as a queue
  typedef struct {
    int               line;
    logic [TAG_W-1:0] tag;
    int               acc;
  } rd_t;

  rd_t               sb[$];
  logic [DATA_W-1:0] mdl_mem [int];
  int                cyc = 0;
  int                beat = 0;
  int                last_pop = 0;
  int                wr_line = 0;
  int                wr_beat = 0;
  bit                wr_active = 0;
  bit                seen = 0;
  int unsigned       m_rd = 0;
  int unsigned       m_wr = 0;
  int                ncmp = 0;
  int                nerr = 0;
  bit                rnd_done = 0;

  function automatic logic [DATA_W-1:0] mem_rd(input int w);
    if (mdl_mem.exists(w)) return mdl_mem[w];
    return '0;
  endfunction

  // The head emits once its latency has elapsed and the previous read has popped.
  function automatic bit head_due();
    int due;
    if (sb.size() == 0) return 0;
    due = sb[0].acc + LATENCY;
    if (last_pop > due) due = last_pop;
    return cyc >= due;
  endfunction

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    beat = 0; last_pop = 0; wr_active = 0; wr_beat = 0;
    m_rd = 0; m_wr = 0; seen = 0;
  endtask

  // Observer: applies every handshake at the clock edge to the model
  initial begin
    forever begin
      int  e;
      bit  acc_ok;
      @(posedge clk);
      e = cyc + 1;
      if (reset_n) begin
        if (seen) begin
          acc_ok = !wr_active && (cmd_rw || sb.size() < MAX_OUT);
          if (head_due() && resp_ready) begin
            beat++;
            if (beat == BEATS) begin
              void'(sb.pop_front());
              beat = 0;
              last_pop = e;
            end
          end
          if (wr_active && data_valid) begin
            mdl_mem[wr_line * BEATS + wr_beat] = data_bits;
            wr_beat++;
            if (wr_beat == BEATS) begin
              wr_active = 0;
              m_wr++;
            end
          end
          if (cmd_valid && acc_ok) begin
            if (cmd_rw) begin
              wr_active = 1;
              wr_beat = 0;
              wr_line = int'(cmd_addr[DEPTH_LOG2-1:0]);
            end else begin
              sb.push_back('{line: int'(cmd_addr[DEPTH_LOG2-1:0]), tag: cmd_tag, acc: e});
              m_rd++;
            end
          end
        end
        seen = 1;
      end
      cyc = e;
    end
  end

  // Monitor: compares the DUT's outputs against the model every cycle
  initial begin
    forever begin
      bit exp_v;
      @(negedge clk);
      if (reset_n && seen) begin
        exp_v = head_due();
        chk("cmd_ready", cmd_ready, !wr_active && (cmd_rw || sb.size() < MAX_OUT));
        chk("data_ready", data_ready, wr_active);
        chk("resp_valid", resp_valid, exp_v);
        if (exp_v && resp_valid) begin
          chk("resp_tag", resp_tag, sb[0].tag);
          chk("resp_data", resp_data, mem_rd(sb[0].line * BEATS + beat));
        end
        chk("rd_count", rd_count, m_rd);
        chk("wr_count", wr_count, m_wr);
      end
    end
  end

  task automatic send_cmd(input bit rw, input int line, input logic [TAG_W-1:0] tag);
    int n = 0;
    cmd_valid = 1;
    cmd_rw    = rw;
    cmd_tag   = tag;
    cmd_addr  = {ADDR_W'($urandom_range(0, 15)), DEPTH_LOG2'(line)};
    do begin
      @(negedge clk);
      n++;
    end while (!cmd_ready && n < 1000);
    if (!cmd_ready) chk("cmd_accept_timeout", 0, 1);
    @(posedge clk);
    #1 cmd_valid = 0;
  endtask

  task automatic write_beat(input logic [DATA_W-1:0] d);
    int n = 0;
    data_valid = 1;
    data_bits  = d;
    do begin
      @(negedge clk);
      n++;
    end while (!data_ready && n < 1000);
    if (!data_ready) chk("data_accept_timeout", 0, 1);
    @(posedge clk);
    #1 data_valid = 0;
  endtask

  task automatic write_line(input int line, input logic [BEATS*DATA_W-1:0] d, input bit gap);
    send_cmd(1, line, '0);
    for (int i = 0; i < BEATS; i++) begin
      if (gap && i > 0) begin
        @(posedge clk);
        #1;
      end
      write_beat(d[i*DATA_W +: DATA_W]);
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || wr_active) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0 || wr_active) chk("drain_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [BEATS*DATA_W-1:0] rand_line();
    logic [BEATS*DATA_W-1:0] v;
    for (int i = 0; i < BEATS*DATA_W/32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 0; cmd_valid = 0; cmd_rw = 0; cmd_addr = '0; cmd_tag = '0;
    data_valid = 0; data_bits = '0; resp_ready = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_data_ready", data_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_resp_tag", resp_tag, 0);
    chk("rst_rd_count", rd_count, 0);
    chk("rst_wr_count", wr_count, 0);
    reset_n = 1;
    @(posedge clk);
    #1;

    // Read of never-written line returns zeros after LATENCY
    resp_ready = 1;
    send_cmd(0, 5, 5'd3);
    drain();
    chk("rd_count_after_first", rd_count, 1);

    // Write with data_valid gaps, then read back
    write_line(5, {128'h44, 128'h33, 128'h22, 128'h11}, 1);
    drain();
    chk("wr_count_after_first", wr_count, 1);
    send_cmd(0, 5, 5'd7);
    drain();

    // Queue fills with responses blocked; order kept when released
    resp_ready = 0;
    fork
      for (int t = 0; t < 5; t++) send_cmd(0, t + 1, TAG_W'(t));
      begin
        repeat (20) @(posedge clk);
        #1 resp_ready = 1;
      end
    join
    drain();

    // Write completing before countdown expiry is visible to the earlier read
    send_cmd(0, 7, 5'd9);
    write_line(7, {4{128'hAA}}, 0);
    drain();

    // Reset in the middle of a write with two reads pending
    write_line(9, {128'h94, 128'h93, 128'h92, 128'h91}, 0);
    drain();
    resp_ready = 0;
    send_cmd(0, 9, 5'd1);
    send_cmd(0, 9, 5'd2);
    send_cmd(1, 9, '0);
    write_beat(128'hB0);
    write_beat(128'hB1);
    repeat (6) @(posedge clk);
    #2 reset_n = 0;
    model_reset();
    #1;
    chk("midrst_resp_valid", resp_valid, 0);
    chk("midrst_data_ready", data_ready, 0);
    chk("midrst_cmd_ready", cmd_ready, 0);
    chk("midrst_rd_count", rd_count, 0);
    chk("midrst_wr_count", wr_count, 0);
    chk("midrst_resp_data", resp_data, 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
    resp_ready = 1;
    @(posedge clk);
    #1;
    send_cmd(0, 9, 5'd5);
    drain();

    // Hold resp_ready low for three cycles on beat 2
    send_cmd(0, 5, 5'd6);
    begin
      int n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!(resp_valid && beat == 2) && n < 100);
      if (!(resp_valid && beat == 2)) chk("beat2_wait_timeout", 0, 1);
      resp_ready = 0;
      repeat (3) @(posedge clk);
      #1 resp_ready = 1;
    end
    drain();

    // Randomised traffic with random response backpressure
    fork
      begin
        for (int k = 0; k < 120; k++) begin
          if ($urandom_range(0, 2) == 0)
            write_line($urandom_range(0, 7), rand_line(), 1'($urandom_range(0, 1)));
          else
            send_cmd(0, $urandom_range(0, 7), TAG_W'($urandom));
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
        end
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1 resp_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    resp_ready = 1;
    drain();
    chk("final_rd_count", rd_count, m_rd);
    chk("final_wr_count", wr_count, m_wr);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
